// File: rtl/regfile_pkg.sv
// Shared register-file definitions: clear-FSM state encoding and default geometry.
// Optional write-to-read bypass in regfile_sb is enabled by defining REGFILE_SB_BYPASS_EN.
package regfile_pkg;

    localparam int DEFAULT_WIDTH = 32;
    localparam int DEFAULT_DEPTH = 32;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_READY = 1'b1
    } state_e;

endpackage

// File: rtl/regfile_sb_scoreboard.sv
// Pending-write scoreboard: one bit per register, set by mark, cleared by writeback.
// A mark and a writeback to the same register in one cycle leave the bit set.
module regfile_sb_scoreboard
    import regfile_pkg::*;
#(
    parameter int DEPTH = DEFAULT_DEPTH,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n_i,
    input  logic             en_i,
    input  logic             mark_i,
    input  logic [AW-1:0]    ma_i,
    input  logic             we_i,
    input  logic [AW-1:0]    wa_i,
    output logic [DEPTH-1:0] pend_o
);

    logic [DEPTH-1:0] pend_q;
    logic [DEPTH-1:0] pend_d;

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_pend
            if (gi == 0) begin : g_zero
                assign pend_d[gi] = 1'b0;
            end else begin : g_bit
                logic set_w;
                logic clr_w;
                assign set_w = en_i && mark_i && (ma_i == AW'(gi));
                assign clr_w = en_i && we_i && (wa_i == AW'(gi));
                // New producer issued wins over the retiring one.
                assign pend_d[gi] = set_w ? 1'b1 : (clr_w ? 1'b0 : pend_q[gi]);
            end
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n_i) begin
        if (!rst_n_i) begin
            pend_q <= '0;
        end else begin
            pend_q <= pend_d;
        end
    end

    assign pend_o = pend_q;

endmodule

// File: rtl/regfile_sb.sv
// Two-read/one-write register file with r0 hardwired to zero, post-reset clear engine,
// pending scoreboard and optional same-cycle bypass (define REGFILE_SB_BYPASS_EN).
module regfile_sb
    import regfile_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int DEPTH = DEFAULT_DEPTH,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [AW-1:0]    ra1,
    input  logic [AW-1:0]    ra2,
    output logic [WIDTH-1:0] rd1,
    output logic [WIDTH-1:0] rd2,
    output logic             busy1,
    output logic             busy2,
    input  logic             we3,
    input  logic [AW-1:0]    wa3,
    input  logic [WIDTH-1:0] wd3,
    input  logic             mark,
    input  logic [AW-1:0]    ma,
    output logic             ready
);

    state_e            state_q;
    state_e            state_d;
    logic [AW-1:0]     ptr_q;
    logic [AW-1:0]     ptr_d;
    logic              clearing;

    logic [WIDTH-1:0]  mem [DEPTH];
    logic              mem_we;
    logic [AW-1:0]     mem_wa;
    logic [WIDTH-1:0]  mem_wd;
    logic [DEPTH-1:0]  pend;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_CLEAR;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        case (state_q)
            ST_CLEAR: begin
                ptr_d = ptr_q + 1'b1;
                if (ptr_q == AW'(DEPTH - 1)) begin
                    state_d = ST_READY;
                end
            end
            default: state_d = ST_READY;
        endcase
    end

    always_comb begin
        ready    = (state_q == ST_READY);
        clearing = (state_q == ST_CLEAR);
    end

    // The array has no reset; the clear engine walks it to zero instead.
    assign mem_we = clearing || (we3 && (wa3 != '0));
    assign mem_wa = clearing ? ptr_q : wa3;
    assign mem_wd = clearing ? '0 : wd3;

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_wa] <= mem_wd;
        end
    end

    regfile_sb_scoreboard #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_scoreboard (
        .clk     (clk),
        .rst_n_i (reset_n),
        .en_i    (ready),
        .mark_i  (mark),
        .ma_i    (ma),
        .we_i    (we3),
        .wa_i    (wa3),
        .pend_o  (pend)
    );

    logic [AW-1:0]    ra_w   [2];
    logic [WIDTH-1:0] rd_w   [2];
    logic             busy_w [2];

    assign ra_w[0] = ra1;
    assign ra_w[1] = ra2;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_rport
            logic hit;
`ifdef REGFILE_SB_BYPASS_EN
            assign hit = ready && we3 && (wa3 != '0) && (ra_w[gi] == wa3);
`else
            assign hit = 1'b0;
`endif
            always_comb begin
                rd_w[gi] = '0;
                if (ready && (ra_w[gi] != '0)) begin
                    rd_w[gi] = hit ? wd3 : mem[ra_w[gi]];
                end
            end
            assign busy_w[gi] = pend[ra_w[gi]] && !hit;
        end
    endgenerate

    assign rd1   = rd_w[0];
    assign rd2   = rd_w[1];
    assign busy1 = busy_w[0];
    assign busy2 = busy_w[1];

endmodule

// File: tb/tb_regfile_sb.sv
// Directed bench for regfile_sb: default 32x32 instance plus a 16-bit x 8-entry instance.
module tb_regfile_sb;

`ifdef REGFILE_SB_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Default-geometry instance
    logic        reset_n = 1'b0;
    logic [4:0]  ra1 = '0, ra2 = '0, wa3 = '0, ma = '0;
    logic [31:0] rd1, rd2, wd3 = '0;
    logic        busy1, busy2, we3 = 1'b0, mark = 1'b0, ready;

    // Small-geometry instance
    logic        reset_n_s = 1'b0;
    logic [2:0]  ra1_s = '0, ra2_s = '0, wa3_s = '0, ma_s = '0;
    logic [15:0] rd1_s, rd2_s, wd3_s = '0;
    logic        busy1_s, busy2_s, we3_s = 1'b0, mark_s = 1'b0, ready_s;

    int checks   = 0;
    int failures = 0;

    regfile_sb dut (
        .clk(clk), .reset_n(reset_n),
        .ra1(ra1), .ra2(ra2), .rd1(rd1), .rd2(rd2),
        .busy1(busy1), .busy2(busy2),
        .we3(we3), .wa3(wa3), .wd3(wd3),
        .mark(mark), .ma(ma), .ready(ready)
    );

    regfile_sb #(.WIDTH(16), .DEPTH(8)) dut_s (
        .clk(clk), .reset_n(reset_n_s),
        .ra1(ra1_s), .ra2(ra2_s), .rd1(rd1_s), .rd2(rd2_s),
        .busy1(busy1_s), .busy2(busy2_s),
        .we3(we3_s), .wa3(wa3_s), .wd3(wd3_s),
        .mark(mark_s), .ma(ma_s), .ready(ready_s)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        $display("check %s observed=%h expected=%h", tag, obs, exp);
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [15:0] v;

        // Reset state
        repeat (3) tick();
        ra1 = 5'd9;
        #1;
        check("rst_ready", {31'b0, ready}, 32'd0);
        check("rst_busy1", {31'b0, busy1}, 32'd0);
        check("rst_rd1", rd1, 32'd0);

        // Release; writes and marks held through CLEAR must be lost
        reset_n = 1'b1;
        we3 = 1'b1; wa3 = 5'd9; wd3 = 32'hFFFF_FFFF;
        mark = 1'b1; ma = 5'd9;
        for (int k = 1; k <= 32; k++) begin
            tick();
            check($sformatf("clr_ready_k%0d", k), {31'b0, ready}, (k == 32) ? 32'd1 : 32'd0);
        end
        we3 = 1'b0; mark = 1'b0;
        #1;
        check("clr_lost_wr", rd1, 32'd0);
        check("clr_lost_mark", {31'b0, busy1}, 32'd0);

        for (int i = 1; i < 32; i++) begin
            ra1 = 5'(i); ra2 = 5'(i);
            #1;
            check($sformatf("zero_rd1_r%0d", i), rd1, 32'd0);
            check($sformatf("zero_rd2_r%0d", i), rd2, 32'd0);
        end

        // Write r5, visible next cycle
        we3 = 1'b1; wa3 = 5'd5; wd3 = 32'hDEAD_BEEF; ra1 = 5'd5;
        #1;
        check("wr5_same_cycle", rd1, BYP ? 32'hDEAD_BEEF : 32'd0);
        tick();
        we3 = 1'b0;
        #1;
        check("wr5_next_cycle", rd1, 32'hDEAD_BEEF);

        // Write to r0 is discarded
        we3 = 1'b1; wa3 = 5'd0; wd3 = 32'h1234; ra2 = 5'd0; ra1 = 5'd0;
        tick();
        we3 = 1'b0;
        #1;
        check("r0_rd2", rd2, 32'd0);
        check("r0_rd1", rd1, 32'd0);

        // Scoreboard: mark, then retire
        ra1 = 5'd7; ra2 = 5'd7; mark = 1'b1; ma = 5'd7;
        #1;
        check("mark7_same_cycle", {31'b0, busy1}, 32'd0);
        tick();
        mark = 1'b0;
        #1;
        check("mark7_busy1", {31'b0, busy1}, 32'd1);
        check("mark7_busy2", {31'b0, busy2}, 32'd1);
        we3 = 1'b1; wa3 = 5'd7; wd3 = 32'h77;
        #1;
        check("wr7_busy_same", {31'b0, busy1}, BYP ? 32'd0 : 32'd1);
        tick();
        we3 = 1'b0;
        #1;
        check("wr7_busy_after", {31'b0, busy1}, 32'd0);
        check("wr7_rd1", rd1, 32'h77);

        // Mark and write same register same cycle: set wins
        mark = 1'b1; ma = 5'd7; we3 = 1'b1; wa3 = 5'd7; wd3 = 32'h88;
        tick();
        mark = 1'b0; we3 = 1'b0;
        #1;
        check("markwr7_busy", {31'b0, busy1}, 32'd1);
        check("markwr7_rd1", rd1, 32'h88);

        // Two ports reading the register being written
        ra1 = 5'd3; ra2 = 5'd3; we3 = 1'b1; wa3 = 5'd3; wd3 = 32'hA5A5_A5A5;
        #1;
        check("byp_rd1_same", rd1, BYP ? 32'hA5A5_A5A5 : 32'd0);
        check("byp_rd2_same", rd2, BYP ? 32'hA5A5_A5A5 : 32'd0);
        tick();
        we3 = 1'b0;
        #1;
        check("byp_rd1_next", rd1, 32'hA5A5_A5A5);
        check("byp_rd2_next", rd2, 32'hA5A5_A5A5);

        // Asynchronous reset from READY, then again at ptr = 10 mid-clear
        ra1 = 5'd7;
        #1;
        check("pre_rst_busy", {31'b0, busy1}, 32'd1);
        reset_n = 1'b0;
        #1;
        check("arst_ready", {31'b0, ready}, 32'd0);
        check("arst_busy", {31'b0, busy1}, 32'd0);
        check("arst_rd1", rd1, 32'd0);
        tick();
        reset_n = 1'b1;
        repeat (10) tick();
        check("mid_clr_ready", {31'b0, ready}, 32'd0);
        reset_n = 1'b0;
        #1;
        check("mid_rst_ready", {31'b0, ready}, 32'd0);
        tick();
        reset_n = 1'b1;
        for (int k = 1; k <= 32; k++) begin
            tick();
            check($sformatf("reclr_ready_k%0d", k), {31'b0, ready}, (k == 32) ? 32'd1 : 32'd0);
        end
        ra1 = 5'd5; ra2 = 5'd7;
        #1;
        check("reclr_r5", rd1, 32'd0);
        check("reclr_r7", rd2, 32'd0);
        check("reclr_busy7", {31'b0, busy2}, 32'd0);

        // Small geometry: 8-cycle clear, then per-address write/mark
        reset_n_s = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            tick();
            check($sformatf("s_ready_k%0d", k), {31'b0, ready_s}, (k == 8) ? 32'd1 : 32'd0);
        end
        for (int a = 1; a < 8; a++) begin
            v = 16'(a * 16'h1111);
            ra1_s = 3'(a); ra2_s = 3'(a);
            mark_s = 1'b1; ma_s = 3'(a); we3_s = 1'b1; wa3_s = 3'(a); wd3_s = v;
            tick();
            mark_s = 1'b0; we3_s = 1'b0;
            #1;
            check($sformatf("s_rd1_r%0d", a), {16'b0, rd1_s}, {16'b0, v});
            check($sformatf("s_busy1_r%0d", a), {31'b0, busy1_s}, 32'd1);
            we3_s = 1'b1; wd3_s = ~v;
            tick();
            we3_s = 1'b0;
            #1;
            check($sformatf("s_busy2_r%0d", a), {31'b0, busy2_s}, 32'd0);
            check($sformatf("s_rd2_r%0d", a), {16'b0, rd2_s}, {16'b0, ~v});
        end
        ra1_s = 3'd0;
        #1;
        check("s_r0", {16'b0, rd1_s}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
